// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding with youngest-first priority across N_SRC pipeline
// stages, plus load-use hazard detection holding a LOAD_STALL-cycle stall.
module fwd_hazard_unit #(
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned NB_REG      = 32,
  parameter int unsigned N_SRC       = 3,
  parameter int unsigned N_LOAD_HAZ  = 1,
  parameter int unsigned LOAD_STALL  = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [NB_REG_ADDR-1:0]        i_rs,
  input  logic [NB_REG_ADDR-1:0]        i_rt,
  input  logic                          i_use_rs,
  input  logic                          i_use_rt,
  input  logic [N_SRC-1:0]              i_we,
  input  logic [N_SRC-1:0]              i_load,
  input  logic [N_SRC*NB_REG_ADDR-1:0]  i_rd,
  input  logic [N_SRC*NB_REG-1:0]       i_data,
  output logic [NB_REG-1:0]             o_data_a,
  output logic [NB_REG-1:0]             o_data_b,
  output logic                          o_mux_a,
  output logic                          o_mux_b,
  output logic                          o_bubble,
  output logic                          o_stall
);

  localparam int unsigned CNT_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);

  typedef enum logic {ST_IDLE, ST_STALL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SRC-1:0]   match_a, match_b;
  logic               hit_a, hit_b, haz_a, haz_b, haz;
  logic [NB_REG-1:0]  fwd_a, fwd_b;
  logic               stall_c;
  logic [NB_REG-1:0]  data_a_q, data_a_d, data_b_q, data_b_d;
  logic               mux_a_q, mux_a_d, mux_b_q, mux_b_d, bubble_q, bubble_d;

  // Source matching; descending scan so the youngest matching stage wins.
  always_comb begin
    match_a = '0;
    match_b = '0;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    haz_a   = 1'b0;
    haz_b   = 1'b0;
    fwd_a   = '0;
    fwd_b   = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      match_a[k] = i_we[k] && (i_rd[k*NB_REG_ADDR +: NB_REG_ADDR] == i_rs)
                   && (i_rs != '0) && i_use_rs;
      match_b[k] = i_we[k] && (i_rd[k*NB_REG_ADDR +: NB_REG_ADDR] == i_rt)
                   && (i_rt != '0) && i_use_rt;
    end
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        hit_a = 1'b1;
        fwd_a = i_data[k*NB_REG +: NB_REG];
        haz_a = i_load[k] && (k < int'(N_LOAD_HAZ));
      end
      if (match_b[k]) begin
        hit_b = 1'b1;
        fwd_b = i_data[k*NB_REG +: NB_REG];
        haz_b = i_load[k] && (k < int'(N_LOAD_HAZ));
      end
    end
    haz = haz_a || haz_b;
  end

  // Stall FSM: the IDLE cycle that detects the hazard is the first stall cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_c = i_valid && haz;
        if (i_valid && haz && (LOAD_STALL > 1)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_INIT;
        end
      end
      ST_STALL: begin
        stall_c = 1'b1;
        if (i_valid) begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (i_reset) stall_c = 1'b0;
  end

  always_comb begin
    mux_a_d  = !stall_c && hit_a;
    mux_b_d  = !stall_c && hit_b;
    data_a_d = stall_c ? '0 : fwd_a;
    data_b_d = stall_c ? '0 : fwd_b;
    bubble_d = stall_c;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_a_q <= '0;
      data_b_q <= '0;
      mux_a_q  <= 1'b0;
      mux_b_q  <= 1'b0;
      bubble_q <= 1'b0;
    end else if (i_valid) begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      mux_a_q  <= mux_a_d;
      mux_b_q  <= mux_b_d;
      bubble_q <= bubble_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_mux_a  = mux_a_q;
  assign o_mux_b  = mux_b_q;
  assign o_bubble = bubble_q;
  assign o_stall  = stall_c;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two configurations (LOAD_STALL=1/N_LOAD_HAZ=1 and
// LOAD_STALL=3/N_LOAD_HAZ=2) driven in parallel against a stall-budget model.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, valid, use_rs, use_rt;
  logic [4:0]  rs, rt;
  logic [2:0]  we, ld;
  logic [14:0] rd;
  logic [95:0] data;

  logic [31:0] o_da [2];
  logic [31:0] o_db [2];
  logic        o_ma [2];
  logic        o_mb [2];
  logic        o_bub [2];
  logic        o_st [2];

  int errors = 0;
  int checks = 0;

  int ls_p  [2] = '{1, 3};
  int nlh_p [2] = '{1, 2};
  int rem   [2] = '{0, 0};
  logic [31:0] m_da [2];
  logic [31:0] m_db [2];
  logic        m_ma [2];
  logic        m_mb [2];
  logic        m_bub [2];
  logic        st_seen [2];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NB_REG_ADDR(5), .NB_REG(32), .N_SRC(3), .N_LOAD_HAZ(1), .LOAD_STALL(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_rs(rs), .i_rt(rt),
    .i_use_rs(use_rs), .i_use_rt(use_rt), .i_we(we), .i_load(ld), .i_rd(rd), .i_data(data),
    .o_data_a(o_da[0]), .o_data_b(o_db[0]), .o_mux_a(o_ma[0]), .o_mux_b(o_mb[0]),
    .o_bubble(o_bub[0]), .o_stall(o_st[0]));

  fwd_hazard_unit #(.NB_REG_ADDR(5), .NB_REG(32), .N_SRC(3), .N_LOAD_HAZ(2), .LOAD_STALL(3)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_rs(rs), .i_rt(rt),
    .i_use_rs(use_rs), .i_use_rt(use_rt), .i_we(we), .i_load(ld), .i_rd(rd), .i_data(data),
    .o_data_a(o_da[1]), .o_data_b(o_db[1]), .o_mux_a(o_ma[1]), .o_mux_b(o_mb[1]),
    .o_bubble(o_bub[1]), .o_stall(o_st[1]));

  typedef struct {
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [2:0]  we, ld;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic        e_st, e_ma, e_mb, e_bub;
    logic [31:0] e_da, e_db;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Youngest-first search: first stage (lowest index) that writes the register.
  function automatic void find_hit(input logic [4:0] r, input logic u, output bit found, output int idx);
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < 3; k++)
      if (!found && u && r != 5'd0 && we[k] && rd[k*5 +: 5] == r) begin
        found = 1'b1;
        idx   = k;
      end
  endfunction

  task automatic clr();
    rst = 1'b0; valid = 1'b1; rs = '0; rt = '0; use_rs = 1'b0; use_rt = 1'b0;
    we = '0; ld = '0; rd = '0; data = '0;
  endtask

  task automatic src(input int k, input logic w, input logic l, input logic [4:0] r, input logic [31:0] dv);
    we[k] = w;
    ld[k] = l;
    rd[k*5 +: 5] = r;
    data[k*32 +: 32] = dv;
  endtask

  // One clock: check o_stall before the edge, advance the model, check registered outputs.
  task automatic step();
    bit fa, fb;
    int ia, ib;
    bit haz [2];
    bit st [2];
    find_hit(rs, use_rs, fa, ia);
    find_hit(rt, use_rt, fb, ib);
    #2;
    for (int d = 0; d < 2; d++) begin
      haz[d] = (fa && ia < nlh_p[d] && ld[ia]) || (fb && ib < nlh_p[d] && ld[ib]);
      st[d]  = !rst && (rem[d] > 0 || (valid && haz[d]));
      chk($sformatf("stall[%0d]", d), 32'(o_st[d]), 32'(st[d]));
      st_seen[d] = o_st[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rem[d] = 0;
        m_da[d] = '0; m_db[d] = '0; m_ma[d] = 1'b0; m_mb[d] = 1'b0; m_bub[d] = 1'b0;
      end else if (valid) begin
        if (st[d]) begin
          m_da[d] = '0; m_db[d] = '0; m_ma[d] = 1'b0; m_mb[d] = 1'b0; m_bub[d] = 1'b1;
          if (rem[d] > 0) rem[d] = rem[d] - 1;
          else            rem[d] = ls_p[d] - 1;
        end else begin
          m_ma[d]  = fa;
          m_mb[d]  = fb;
          m_da[d]  = fa ? data[ia*32 +: 32] : 32'd0;
          m_db[d]  = fb ? data[ib*32 +: 32] : 32'd0;
          m_bub[d] = 1'b0;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("data_a[%0d]", d), o_da[d], m_da[d]);
      chk($sformatf("data_b[%0d]", d), o_db[d], m_db[d]);
      chk($sformatf("mux_a[%0d]", d), 32'(o_ma[d]), 32'(m_ma[d]));
      chk($sformatf("mux_b[%0d]", d), 32'(o_mb[d]), 32'(m_mb[d]));
      chk($sformatf("bubble[%0d]", d), 32'(o_bub[d]), 32'(m_bub[d]));
    end
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [4:0] rs_v, input logic urs, input logic [4:0] rt_v, input logic urt,
                              input logic [2:0] we_v, input logic [2:0] ld_v,
                              input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic est, input logic ema, input logic [31:0] eda,
                              input logic emb, input logic [31:0] edb, input logic ebub);
    vec_t v;
    v.rs = rs_v; v.urs = urs; v.rt = rt_v; v.urt = urt; v.we = we_v; v.ld = ld_v;
    v.rd0 = r0; v.rd1 = r1; v.rd2 = r2; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.e_st = est; v.e_ma = ema; v.e_da = eda; v.e_mb = emb; v.e_db = edb; v.e_bub = ebub;
    return v;
  endfunction

  initial begin
    // Expectations for the LOAD_STALL=1, N_LOAD_HAZ=1 instance.
    vt.push_back(mk(5'd3, 1, 5'd0, 0, 3'b011, 3'b000, 5'd3, 5'd3, 5'd0, 32'hAAAA, 32'hBBBB, 32'h0,
                    0, 1, 32'hAAAA, 0, 32'h0, 0));
    vt.push_back(mk(5'd0, 1, 5'd4, 0, 3'b011, 3'b000, 5'd0, 5'd4, 5'd0, 32'h1234, 32'h5678, 32'h0,
                    0, 0, 32'h0, 0, 32'h0, 0));
    vt.push_back(mk(5'd0, 0, 5'd5, 1, 3'b001, 3'b001, 5'd5, 5'd0, 5'd0, 32'h5555, 32'h0, 32'h0,
                    1, 0, 32'h0, 0, 32'h0, 1));
    vt.push_back(mk(5'd0, 0, 5'd5, 1, 3'b010, 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'h1111, 32'h0,
                    0, 0, 32'h0, 1, 32'h1111, 0));
    vt.push_back(mk(5'd9, 1, 5'd9, 1, 3'b100, 3'b000, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'hCCCC,
                    0, 1, 32'hCCCC, 1, 32'hCCCC, 0));
    vt.push_back(mk(5'd6, 1, 5'd7, 1, 3'b111, 3'b000, 5'd1, 5'd7, 5'd6, 32'h0101, 32'h7777, 32'h6666,
                    0, 1, 32'h6666, 1, 32'h7777, 0));
    vt.push_back(mk(5'd6, 1, 5'd7, 1, 3'b011, 3'b001, 5'd6, 5'd7, 5'd0, 32'h6060, 32'h7070, 32'h0,
                    1, 0, 32'h0, 0, 32'h0, 1));
    vt.push_back(mk(5'd2, 0, 5'd2, 0, 3'b111, 3'b000, 5'd2, 5'd2, 5'd2, 32'h1, 32'h2, 32'h3,
                    0, 0, 32'h0, 0, 32'h0, 0));

    clr();
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset data_a[%0d]", d), o_da[d], 32'd0);
      chk($sformatf("reset mux_b[%0d]", d), 32'(o_mb[d]), 32'd0);
      chk($sformatf("reset bubble[%0d]", d), 32'(o_bub[d]), 32'd0);
    end
    rst = 1'b0;

    foreach (vt[i]) begin
      clr();
      rs = vt[i].rs; rt = vt[i].rt; use_rs = vt[i].urs; use_rt = vt[i].urt;
      we = vt[i].we; ld = vt[i].ld;
      rd = {vt[i].rd2, vt[i].rd1, vt[i].rd0};
      data = {vt[i].d2, vt[i].d1, vt[i].d0};
      step();
      chk($sformatf("vec%0d stall", i), 32'(st_seen[0]), 32'(vt[i].e_st));
      chk($sformatf("vec%0d mux_a", i), 32'(o_ma[0]), 32'(vt[i].e_ma));
      chk($sformatf("vec%0d data_a", i), o_da[0], vt[i].e_da);
      chk($sformatf("vec%0d mux_b", i), 32'(o_mb[0]), 32'(vt[i].e_mb));
      chk($sformatf("vec%0d data_b", i), o_db[0], vt[i].e_db);
      chk($sformatf("vec%0d bubble", i), 32'(o_bub[0]), 32'(vt[i].e_bub));
    end

    // LOAD_STALL=3: stall holds three valid cycles even once the hazard disappears.
    do_reset();
    use_rt = 1'b1; rt = 5'd5; src(0, 1, 1, 5'd5, 32'h5A5A);
    step();
    chk("ls3 stall t", 32'(st_seen[1]), 32'd1);
    chk("ls3 bubble t", 32'(o_bub[1]), 32'd1);
    clr();
    for (int c = 1; c <= 2; c++) begin
      step();
      chk($sformatf("ls3 stall t+%0d", c), 32'(st_seen[1]), 32'd1);
      chk($sformatf("ls3 bubble t+%0d", c), 32'(o_bub[1]), 32'd1);
    end
    step();
    chk("ls3 stall t+3", 32'(st_seen[1]), 32'd0);
    chk("ls3 bubble t+3", 32'(o_bub[1]), 32'd0);

    // An invalid cycle inside the stall stretches it by one.
    do_reset();
    use_rt = 1'b1; rt = 5'd5; src(0, 1, 1, 5'd5, 32'h5A5A);
    step();
    clr();
    valid = 1'b0;
    step();
    chk("ls3 hold stall", 32'(st_seen[1]), 32'd1);
    valid = 1'b1;
    step();
    step();
    chk("ls3 extended stall", 32'(st_seen[1]), 32'd1);
    step();
    chk("ls3 stall released", 32'(st_seen[1]), 32'd0);

    // Younger non-load match shadows an older load to the same register.
    do_reset();
    use_rs = 1'b1; rs = 5'd7;
    src(0, 1, 0, 5'd7, 32'hD0D0);
    src(1, 1, 1, 5'd7, 32'hD1D1);
    step();
    chk("shadow stall", 32'(st_seen[1]), 32'd0);
    chk("shadow mux_a", 32'(o_ma[1]), 32'd1);
    chk("shadow data_a", o_da[1], 32'hD0D0);

    // Reset during the stall aborts it immediately.
    do_reset();
    use_rt = 1'b1; rt = 5'd5; src(0, 1, 1, 5'd5, 32'h5A5A);
    step();
    rst = 1'b1;
    step();
    chk("rst abort stall", 32'(st_seen[1]), 32'd0);
    chk("rst abort bubble", 32'(o_bub[1]), 32'd0);
    clr();
    step();
    chk("post rst stall", 32'(st_seen[1]), 32'd0);
    chk("post rst mux_b", 32'(o_mb[1]), 32'd0);

    // Randomised traffic over a small register range to force frequent matches.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 39) == 0);
      valid  = ($urandom_range(0, 7) != 0);
      rs     = 5'($urandom_range(0, 3));
      rt     = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom_range(0, 1));
      use_rt = 1'($urandom_range(0, 1));
      we     = 3'($urandom);
      ld     = 3'($urandom);
      for (int k = 0; k < 3; k++) begin
        rd[k*5 +: 5]     = 5'($urandom_range(0, 3));
        data[k*32 +: 32] = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding (short-circuit) unit.
- Selects forwarded operands from N_SRC younger pipeline stages with youngest-first priority. Never forwards register 0.
- Detects load-use hazards and holds a multi-cycle stall through a small FSM.
- Sits at the ID/EX boundary. Registered outputs feed the EX operand muxes. o_stall freezes PC and IF/ID.

Parameters:
- NB_REG_ADDR, 5, register address width.
- NB_REG, 32, data width.
- N_SRC, 3, number of forwarding sources. Index 0 is youngest (EX), then MEM, WB.
- N_LOAD_HAZ, 1, number of youngest sources where load data is not yet available. Range 0..N_SRC.
- LOAD_STALL, 1, total stall cycles per load-use hazard. Must be >= 1.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  pipeline advance enable.
- i_rs  in  NB_REG_ADDR  source A register.
- i_rt  in  NB_REG_ADDR  source B register.
- i_use_rs  in  1  instruction reads rs.
- i_use_rt  in  1  instruction reads rt.
- i_we  in  N_SRC  per-source write enable.
- i_load  in  N_SRC  per-source "instruction is a load".
- i_rd  in  N_SRC*NB_REG_ADDR  per-source destination. Slice k is [k*NB_REG_ADDR +: NB_REG_ADDR].
- i_data  in  N_SRC*NB_REG  per-source result. Slice k is [k*NB_REG +: NB_REG].
- o_data_a  out  NB_REG  forwarded operand A.
- o_data_b  out  NB_REG  forwarded operand B.
- o_mux_a  out  1  select forwarded A.
- o_mux_b  out  1  select forwarded B.
- o_bubble  out  1  EX receives a bubble this cycle.
- o_stall  out  1  combinational stall request.

Behaviour:
- Clock/reset: single clock i_clock; i_reset is synchronous and active-high.
- Source match: match_a[k] = i_we[k] & (i_rd[k]==i_rs) & (i_rs!=0) & i_use_rs. match_b uses i_rt and i_use_rt the same way.
- Priority: hit_a is the lowest k with match_a[k]. hit_b likewise. No match means no forwarding.
- Hazard: haz = (hit_a exists & hit_a < N_LOAD_HAZ & i_load[hit_a]) | (same for b).
  - Older load matches shadowed by a younger non-load match do not cause a hazard.
- FSM states: IDLE, STALL. Down-counter cnt, width clog2(LOAD_STALL).
  - IDLE & i_valid & haz & LOAD_STALL>1 -> STALL, cnt <= LOAD_STALL-2.
  - STALL & i_valid: if cnt==0 -> IDLE, else cnt--.
  - i_valid low: state and cnt hold.
  - While in STALL, haz is ignored; re-evaluation happens on return to IDLE.
- o_stall = ~i_reset & ((IDLE & i_valid & haz) | STALL).
  - Total stall length is exactly LOAD_STALL valid cycles.
  - When LOAD_STALL==1, the FSM never leaves IDLE.
- Registered outputs, updated only when i_valid:
  - If o_stall: o_mux_a/b <= 0, o_data_a/b <= 0, o_bubble <= 1.
  - Otherwise: o_mux_a <= hit_a exists, o_data_a <= i_data[hit_a] (0 if no hit); same for b; o_bubble <= 0.
  - i_valid low: all registered outputs hold.
- Reset values: o_data_a=o_data_b=0, o_mux_a=o_mux_b=0, o_bubble=0, state IDLE, cnt 0.
  - Reset mid-STALL aborts the stall: o_stall is 0 during reset and afterwards until a new hazard.
  - Reset dominates i_valid.
- Simultaneous events:
  - A and B hazards in the same cycle produce one stall, not two.
  - rs==rt with a hit sets both muxes with identical data.
- Latency: forwarding decision to registered output is 1 cycle. o_stall is 0 cycles (same cycle).

Test Plan:
- Defaults. rs=3, use_rs=1; we=3'b011, rd0=3, rd1=3, data0=0xAAAA, data1=0xBBBB, no loads -> next cycle o_mux_a=1, o_data_a=0xAAAA (youngest wins).
- Register 0. rs=0, rd0=0, we0=1 -> o_mux_a=0, o_data_a=0. use_rt=0 with an rt match -> o_mux_b=0.
- Load-use, LOAD_STALL=1. load0=1, rd0=5, rt=5, use_rt=1 -> o_stall=1 for that single cycle, then o_bubble=1, o_mux_b=0. Next cycle: source moved to k=1, no stall -> o_mux_b=1 with data1.
- LOAD_STALL=3. Hazard at cycle t -> o_stall high for t, t+1, t+2 regardless of inputs; o_bubble=1 for three registered cycles. With i_valid low at t+1, the stall extends by one cycle.
- Shadowing. load1=1 and rd1=7 with non-load rd0=7, N_LOAD_HAZ=2 -> no stall, forward data0.
- Reset at t+1 of a LOAD_STALL=3 stall -> o_stall=0 from t+1; all outputs 0 at t+2; state IDLE.
